// File: rtl/fc_fold_sequencer.sv
// Folded binarised fully-connected layer sequencer: streams weight chunks, XNORs them with
// the held input vector, and accumulates external adder-tree popcounts per output neuron.
module fc_fold_sequencer #(
  parameter int DIM_IN  = 110,
  parameter int DIM_OUT = 16,
  parameter int FOLD    = 1,
  parameter int CHUNK_W = (DIM_IN + FOLD - 1) / FOLD,
  parameter int SUM_W   = $clog2(DIM_IN + 1),
  parameter int TREE_W  = 1 + $clog2(CHUNK_W),
  parameter int ADDR_W  = $clog2(DIM_OUT * FOLD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIM_IN-1:0]        in_vec,
  output logic                     wgt_req,
  output logic [ADDR_W-1:0]        wgt_addr,
  input  logic [CHUNK_W-1:0]       wgt_rdata,
  output logic [CHUNK_W-1:0]       tree_addends,
  input  logic [TREE_W-1:0]        tree_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DIM_OUT*SUM_W-1:0] out_sums,
  output logic                     busy
);
  localparam int PAD_W   = FOLD * CHUNK_W;
  localparam int N_W     = (DIM_OUT > 1) ? $clog2(DIM_OUT) : 1;
  localparam int C_W     = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int C_SLOTS = 1 << C_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [PAD_W-1:0]   vec;
  logic [PAD_W-1:0]   pad_mask;
  logic [N_W-1:0]     n_cnt, n_d;
  logic [C_W-1:0]     c_cnt, c_d;
  logic [ADDR_W-1:0]  addr;
  logic               d_valid;
  logic [SUM_W-1:0]   acc [DIM_OUT];
  logic               accept, last_issue;
  logic [CHUNK_W-1:0] in_chunk  [C_SLOTS];
  logic [CHUNK_W-1:0] live_mask [C_SLOTS];

  assign accept     = in_valid && in_ready;
  assign last_issue = (n_cnt == N_W'(DIM_OUT - 1)) && (c_cnt == C_W'(FOLD - 1));
  assign wgt_addr   = addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    wgt_req    = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        wgt_req = 1'b1;
        if (last_issue) state_next = DRAIN;
      end
      DRAIN: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The delayed flag and (n_d, c_d) line up with wgt_rdata, which returns one cycle after each request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec     <= '0;
      n_cnt   <= '0;
      c_cnt   <= '0;
      n_d     <= '0;
      c_d     <= '0;
      addr    <= '0;
      d_valid <= 1'b0;
      for (int i = 0; i < DIM_OUT; i++) acc[i] <= '0;
    end else begin
      d_valid <= (state == RUN);
      n_d     <= n_cnt;
      c_d     <= c_cnt;
      if (accept) begin
        vec   <= PAD_W'(in_vec);
        n_cnt <= '0;
        c_cnt <= '0;
        addr  <= '0;
        for (int i = 0; i < DIM_OUT; i++) acc[i] <= '0;
      end else if (state == RUN && !last_issue) begin
        addr <= addr + 1'b1;
        if (c_cnt == C_W'(FOLD - 1)) begin
          c_cnt <= '0;
          n_cnt <= n_cnt + 1'b1;
        end else begin
          c_cnt <= c_cnt + 1'b1;
        end
      end
      if (d_valid) acc[n_d] <= acc[n_d] + SUM_W'(tree_sum);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PAD_W; gi++) begin : g_pad
      assign pad_mask[gi] = (gi < DIM_IN);
    end
    // Chunk slots beyond FOLD exist only so c_d can index a power-of-two array.
    for (gi = 0; gi < C_SLOTS; gi++) begin : g_chunk
      if (gi < FOLD) begin : g_live
        assign in_chunk[gi]  = vec[gi*CHUNK_W +: CHUNK_W];
        assign live_mask[gi] = pad_mask[gi*CHUNK_W +: CHUNK_W];
      end else begin : g_unused
        assign in_chunk[gi]  = '0;
        assign live_mask[gi] = '0;
      end
    end
    for (gi = 0; gi < DIM_OUT; gi++) begin : g_out
      assign out_sums[gi*SUM_W +: SUM_W] = acc[gi];
    end
  endgenerate

  assign tree_addends = d_valid ? (~(in_chunk[c_d] ^ wgt_rdata) & live_mask[c_d]) : '0;

endmodule

// File: tb/tb_fc_fold_sequencer.sv
// Bench for fc_fold_sequencer: FOLD=1 and FOLD=4 instances sharing stimulus, with bench-side
// weight memories, popcount adder trees and an XNOR-popcount reference model.
module tb_fc_fold_sequencer;
  localparam int DIN  = 110;
  localparam int DOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           sel = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [DIN-1:0] in_vec = '0;

  logic         in_ready1, wgt_req1, out_valid1, busy1;
  logic [3:0]   wgt_addr1;
  logic [109:0] wgt_rdata1, tree_addends1;
  logic [7:0]   tree_sum1;
  logic [111:0] out_sums1;

  logic         in_ready4, wgt_req4, out_valid4, busy4;
  logic [5:0]   wgt_addr4;
  logic [27:0]  wgt_rdata4, tree_addends4;
  logic [5:0]   tree_sum4;
  logic [111:0] out_sums4;

  fc_fold_sequencer #(.DIM_IN(DIN), .DIM_OUT(DOUT), .FOLD(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready1), .in_vec(in_vec),
    .wgt_req(wgt_req1), .wgt_addr(wgt_addr1), .wgt_rdata(wgt_rdata1),
    .tree_addends(tree_addends1), .tree_sum(tree_sum1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sums(out_sums1), .busy(busy1));

  fc_fold_sequencer #(.DIM_IN(DIN), .DIM_OUT(DOUT), .FOLD(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready4), .in_vec(in_vec),
    .wgt_req(wgt_req4), .wgt_addr(wgt_addr4), .wgt_rdata(wgt_rdata4),
    .tree_addends(tree_addends4), .tree_sum(tree_sum4), .out_valid(out_valid4),
    .out_ready(out_ready), .out_sums(out_sums4), .busy(busy4));

  assign tree_sum1 = 8'($countones(tree_addends1));
  assign tree_sum4 = 6'($countones(tree_addends4));

  logic [DIN-1:0] w_row [DOUT];
  logic [1:0]     pad_junk [DOUT];

  function automatic logic [109:0] rnd_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[109:0];
  endfunction

  function automatic logic [27:0] chunk4(input logic [5:0] a);
    logic [111:0] p;
    p = {pad_junk[a[5:2]], w_row[a[5:2]]};
    return p[a[1:0]*28 +: 28];
  endfunction

  // Read data is garbage whenever no request was made the cycle before.
  always @(posedge clk) begin
    wgt_rdata1 <= wgt_req1 ? w_row[wgt_addr1] : rnd_vec();
    wgt_rdata4 <= wgt_req4 ? chunk4(wgt_addr4) : 28'(rnd_vec());
  end

  logic         m_in_ready, m_out_valid, m_busy, m_wgt_req;
  logic [5:0]   m_wgt_addr;
  logic [111:0] m_sums;
  assign m_in_ready  = sel ? in_ready4  : in_ready1;
  assign m_out_valid = sel ? out_valid4 : out_valid1;
  assign m_busy      = sel ? busy4      : busy1;
  assign m_wgt_req   = sel ? wgt_req4   : wgt_req1;
  assign m_wgt_addr  = sel ? wgt_addr4  : {2'b00, wgt_addr1};
  assign m_sums      = sel ? out_sums4  : out_sums1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [111:0] model(input logic [109:0] v);
    logic [111:0] r;
    r = '0;
    for (int n = 0; n < DOUT; n++) r[n*7 +: 7] = 7'(DIN - $countones(v ^ w_row[n]));
    return r;
  endfunction

  task automatic set_weights(input int mode, input logic [109:0] v);
    for (int n = 0; n < DOUT; n++) begin
      case (mode)
        0:       w_row[n] = '1;
        1:       w_row[n] = '0;
        2:       w_row[n] = (n % 2 == 0) ? v : ~v;
        3:       w_row[n] = (n % 2 == 0) ? ~v : v;
        default: w_row[n] = rnd_vec();
      endcase
      pad_junk[n] = (mode == 1) ? 2'b00 : 2'($urandom);
    end
  endtask

  task automatic accept_vec(input logic [109:0] v);
    int t;
    t = 0;
    while (!m_in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("accept_ready", 128'(m_in_ready), 128'(1));
    in_vec = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nreq, output int aerr);
    lat = 1; nreq = 0; aerr = 0;
    while (!m_out_valid && lat < 300) begin
      if (m_wgt_req) begin
        if (int'(m_wgt_addr) != nreq) aerr++;
        nreq++;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_txn(input string tag, input logic [109:0] v, input logic [111:0] exp);
    int lat, nreq, aerr, exp_lat;
    exp_lat = sel ? 66 : 18;
    accept_vec(v);
    wait_done(lat, nreq, aerr);
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_nreq"}, 128'(nreq), 128'(exp_lat - 2));
    chk({tag, "_addr"}, 128'(aerr), 128'(0));
    chk({tag, "_sums"}, 128'(m_sums), 128'(exp));
    $display("txn %s fold=%0d vec=%h lat=%0d sums=%h", tag, sel ? 4 : 1, v, lat, m_sums);
    if (!out_ready) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_release"}, 128'({m_out_valid, m_in_ready}), 128'(2'b01));
    end
  endtask

  typedef struct {
    int           fold;
    logic [109:0] vec;
    int           wmode;
    int           exp_even;
    int           exp_odd;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[6];
    logic [109:0] ones, zeros, alt, v1, v2;
    logic [111:0] expw, snap;
    int           lat, nreq, aerr, t;
    logic         seen;

    ones = '1; zeros = '0; alt = {55{2'b01}};
    tbl[0] = '{1, ones,  0, 110, 110};
    tbl[1] = '{4, zeros, 1, 110, 110};
    tbl[2] = '{4, alt,   2, 110, 0};
    tbl[3] = '{1, alt,   3, 0,   110};
    tbl[4] = '{4, ones,  1, 0,   0};
    tbl[5] = '{1, zeros, 0, 0,   0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'({in_ready1, in_ready4}), 128'(2'b11));
    chk("rst_busy", 128'({busy1, busy4}), 128'(0));
    chk("rst_out_valid", 128'({out_valid1, out_valid4}), 128'(0));
    chk("rst_wgt_req", 128'({wgt_req1, wgt_req4}), 128'(0));
    chk("rst_wgt_addr", 128'({wgt_addr1, wgt_addr4}), 128'(0));
    chk("rst_sums", 128'(out_sums1 | out_sums4), 128'(0));
    chk("rst_addends", 128'(tree_addends1 | 110'(tree_addends4)), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      sel = (tbl[i].fold == 4);
      set_weights(tbl[i].wmode, tbl[i].vec);
      expw = '0;
      for (int n = 0; n < DOUT; n++) expw[n*7 +: 7] = 7'((n % 2) ? tbl[i].exp_odd : tbl[i].exp_even);
      run_txn($sformatf("tbl%0d", i), tbl[i].vec, expw);
    end

    for (int i = 0; i < 10; i++) begin
      sel = (i >= 5);
      set_weights(4, zeros);
      v1 = rnd_vec();
      run_txn($sformatf("rand%0d", i), v1, model(v1));
    end

    // Backpressure in DONE, ignored in_valid pulse, then immediate second vector.
    sel = 1'b0;
    set_weights(4, zeros);
    v1 = rnd_vec();
    accept_vec(v1);
    wait_done(lat, nreq, aerr);
    chk("bp_lat", 128'(lat), 128'(18));
    snap = m_sums;
    chk("bp_sums", 128'(snap), 128'(model(v1)));
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_vec = rnd_vec();
        in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_hold_valid", 128'(m_out_valid), 128'(1));
      chk("bp_hold_sums", 128'(m_sums), 128'(snap));
      chk("bp_hold_ready", 128'(m_in_ready), 128'(0));
    end
    $display("txn backpressure vec=%h sums=%h", v1, snap);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle", 128'({m_out_valid, m_in_ready, m_busy}), 128'(3'b010));
    v2 = rnd_vec();
    in_vec = v2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", 128'({m_busy, m_in_ready}), 128'(2'b10));
    wait_done(lat, nreq, aerr);
    chk("bp_second_lat", 128'(lat), 128'(18));
    chk("bp_second_sums", 128'(m_sums), 128'(model(v2)));
    $display("txn second vec=%h sums=%h", v2, m_sums);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while neuron 7 is being fetched.
    sel = 1'b1;
    set_weights(4, zeros);
    v1 = rnd_vec();
    accept_vec(v1);
    t = 0;
    while (m_wgt_addr != 6'd29 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_rst_reach", 128'(m_wgt_addr), 128'(29));
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 128'({m_in_ready, m_wgt_req, m_out_valid, m_busy}), 128'(4'b1000));
    chk("mid_rst_addr", 128'(m_wgt_addr), 128'(0));
    chk("mid_rst_sums", 128'(m_sums), 128'(0));
    chk("mid_rst_addends", 128'(tree_addends4), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (m_out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_output", 128'(seen), 128'(0));
    $display("txn reset_abort vec=%h", v1);
    v2 = rnd_vec();
    run_txn("after_rst", v2, model(v2));

    // Back-to-back vectors with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel = (i >= 3);
      if (i == 0 || i == 3) set_weights(4, zeros);
      v1 = rnd_vec();
      run_txn($sformatf("b2b%0d", i), v1, model(v1));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_final_idle", 128'({m_out_valid, m_in_ready}), 128'(2'b01));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fc_fold_sequencer.md
Name: fc_fold_sequencer

Overview:
Sequencer for a binarised fully-connected layer built around the external unsigned 1-bit adder tree (popcount). It accepts one DIM_IN-bit input vector and fetches weight rows from a single-port weight memory, one chunk per cycle. Each chunk is XNORed with the matching input chunk and presented to the adder tree. The returned chunk popcounts are accumulated per output neuron over FOLD passes. All DIM_OUT sums are returned together as one output word.

Parameters:
DIM_IN, `DIM_IN, input vector width in bits
DIM_OUT, 16, number of output neurons
FOLD, 1, chunks per neuron row; CHUNK_W = ceil(DIM_IN/FOLD)
SUM_W, $clog2(DIM_IN+1), width of each neuron sum
TREE_W, 1+$clog2(CHUNK_W), adder-tree sum width (must match tree OUT_WIDTH)
ADDR_W, $clog2(DIM_OUT*FOLD), weight memory address width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input vector offered
in_ready  out  1  sequencer can accept a vector
in_vec  in  DIM_IN  input activations, bit i = activation i
wgt_req  out  1  weight read strobe
wgt_addr  out  ADDR_W  weight row address = n*FOLD + c
wgt_rdata  in  CHUNK_W  weight chunk; valid exactly 1 cycle after wgt_req
tree_addends  out  CHUNK_W  1-bit addends to the adder tree (combinational)
tree_sum  in  TREE_W  adder-tree sum of tree_addends (combinational)
out_valid  out  1  out_sums valid
out_ready  in  1  consumer takes out_sums
out_sums  out  DIM_OUT*SUM_W  neuron n occupies bits [n*SUM_W +: SUM_W]
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state IDLE; in_ready=1; wgt_req=0; wgt_addr=0; out_valid=0; out_sums=0; busy=0; all counters and the data-valid flag cleared. Any operation in flight is abandoned and produces no output.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_vec, zero-pad to FOLD*CHUNK_W bits, zero all accumulators, go to RUN.
  - RUN: wgt_req=1, one address per cycle, c inner counter, n outer counter. The cycle issuing n=DIM_OUT-1, c=FOLD-1 moves to DRAIN.
  - DRAIN: wgt_req=0. Last data beat accumulated. Go to DONE.
  - DONE: out_valid=1, out_sums stable. On out_ready, go to IDLE and drop out_valid.
- Datapath and pipelining:
  - A delayed flag and delayed (n_d, c_d) follow each request by one cycle.
  - In any cycle where the delayed flag is set: tree_addends[k] = ~(in_chunk[c_d][k] ^ wgt_rdata[k]), forced to 0 when c_d*CHUNK_W + k >= DIM_IN (padding never counts).
  - In that same cycle, acc[n_d] += tree_sum. The accumulator is SUM_W wide and cannot overflow, since the maximum value is DIM_IN.
  - When the delayed flag is clear, tree_addends=0.
- Latency: with accept on edge k, RUN covers cycles k+1 .. k+N, where N = DIM_OUT*FOLD. DRAIN is cycle k+N+1. out_valid rises in cycle k+N+2.
- Throughput: one vector per N+3 cycles minimum. There is no overlap: in_ready=0 from the accept edge until DONE exits. in_valid while busy is ignored and the vector is held by the producer.
- Backpressure: out_ready low holds DONE indefinitely, with out_sums and out_valid unchanged.
- Memory contract: wgt_addr is meaningful only while wgt_req=1, and holds its last value otherwise. wgt_rdata is sampled only on the delayed flag.
- FOLD=1: c is always 0 and the sequencer issues one row per neuron.

Test Plan:
1. DIM_IN=110, DIM_OUT=16, FOLD=1; in_vec all 1, all weights all 1 -> every sum=110. out_valid rises exactly 18 cycles after the accept edge, with wgt_addr 0..15 issued on consecutive cycles.
2. FOLD=4 (CHUNK_W=28); in_vec=0, weights=0 -> every sum=110, not 112, proving padding is masked. wgt_addr runs 0..63, and out_valid arrives 66 cycles after accept.
3. FOLD=4; in_vec=0x5555…; row n weights equal in_vec for even n and ~in_vec for odd n -> sums alternate 110, 0. Random vectors are compared against a reference XNOR-popcount model.
4. Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sums stable and in_ready=0. Pulse in_valid meanwhile -> the vector is not accepted. Raise out_ready -> IDLE next cycle, and a second vector is accepted one cycle later.
5. Assert rst for 1 cycle mid-RUN (n=7) -> outputs take their reset values immediately and out_valid never asserts. A new vector after reset produces correct sums.
6. Issue back-to-back vectors with out_ready tied 1 -> each output matches its own vector, with no accumulator carry-over between vectors.
